wb_port_arbiter: RTL and testbench

Arbiter and scheduler for the single general-register write port at the write-back boundary. Merges three writers: the in-order pipeline write-back stream, the multi-cycle divider, and the load/store unit's late-return path. Produces one registered `reg_we/reg_waddr/reg_wdata` triple per cycle toward the register file. The pipeline has priority. The two secondary sources share leftover slots round-robin. A starvation counter forces a one-cycle pipeline stall so secondary results always drain.

---
 rtl/wb_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Schedules the single general-register write port at the write-back
// boundary. There are three writers:
//   - the in-order pipeline write-back stream, which has priority
//   - the multi-cycle divider
//   - the load/store unit's late-return path
// The divider and the LSU share the slots the pipeline leaves free, in
// round-robin order. A starvation counter forces a one-cycle pipeline stall
// so that a pending secondary result always drains.
//
// Ports:
//   clk, rst                      clock (rising edge); async active-high reset
//   pipe_we_i/waddr_i/wdata_i     pipeline write-back request
//   div_valid_i/waddr_i/wdata_i   divider result; div_ready_o accepts it
//   lsu_valid_i/waddr_i/wdata_i   LSU late-load result; lsu_ready_o accepts it
//   pipe_stall_o                  registered; pipeline freezes and re-presents
//   reg_we_o/waddr_o/wdata_o      registered register-file write triple
module wb_port_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we_i,
  input  logic [AW-1:0] pipe_waddr_i,
  input  logic [DW-1:0] pipe_wdata_i,
  input  logic          div_valid_i,
  input  logic [AW-1:0] div_waddr_i,
  input  logic [DW-1:0] div_wdata_i,
  output logic          div_ready_o,
  input  logic          lsu_valid_i,
  input  logic [AW-1:0] lsu_waddr_i,
  input  logic [DW-1:0] lsu_wdata_i,
  output logic          lsu_ready_o,
  output logic          pipe_stall_o,
  output logic          reg_we_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {RUN, STALL} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;

  logic          sec_slot_p0;
  logic          div_pick_p0;
  logic          lsu_pick_p0;
  logic          pipe_grant_p0;
  logic          vld_p0;
  logic [AW-1:0] waddr_p0;
  logic [DW-1:0] wdata_p0;

  logic          vld_p1;
  logic [AW-1:0] waddr_p1;
  logic [DW-1:0] wdata_p1;

  // Stage p0: grant selection, handshake, next-state
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    starve_cnt_d  = starve_cnt_q;
    sec_slot_p0   = 1'b0;
    div_pick_p0   = 1'b0;
    lsu_pick_p0   = 1'b0;
    pipe_grant_p0 = 1'b0;
    div_ready_o   = 1'b0;
    lsu_ready_o   = 1'b0;
    vld_p0        = 1'b0;
    waddr_p0      = pipe_waddr_i;
    wdata_p0      = pipe_wdata_i;

    // In STALL the pipeline request is ignored; the upstream re-presents it.
    pipe_grant_p0 = (state_q == RUN) && pipe_we_i;
    sec_slot_p0   = !pipe_grant_p0;

    // Preferred source wins if valid, otherwise the other one. Built from
    // valids only, so neither ready ever depends on a ready.
    div_pick_p0 = div_valid_i && (!rr_q || !lsu_valid_i);
    lsu_pick_p0 = lsu_valid_i && ( rr_q || !div_valid_i);

    div_ready_o = !rst && sec_slot_p0 && div_pick_p0;
    lsu_ready_o = !rst && sec_slot_p0 && lsu_pick_p0;

    if (pipe_grant_p0) begin
      vld_p0   = 1'b1;
      waddr_p0 = pipe_waddr_i;
      wdata_p0 = pipe_wdata_i;
    end else if (div_ready_o) begin
      vld_p0   = 1'b1;
      waddr_p0 = div_waddr_i;
      wdata_p0 = div_wdata_i;
    end else if (lsu_ready_o) begin
      vld_p0   = 1'b1;
      waddr_p0 = lsu_waddr_i;
      wdata_p0 = lsu_wdata_i;
    end

    // Point at the source that was not granted.
    if (div_ready_o) begin
      rr_d = 1'b1;
    end else if (lsu_ready_o) begin
      rr_d = 1'b0;
    end

    if (div_ready_o || lsu_ready_o || (!div_valid_i && !lsu_valid_i)) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    case (state_q)
      RUN:     state_d = (starve_cnt_q == LIMIT) ? STALL : RUN;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      rr_q         <= 1'b0;
      starve_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Stage p1: registered write toward the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      // x0 grants consume the slot but never write the register file.
      vld_p1 <= vld_p0 && (waddr_p0 != '0);
      if (vld_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign reg_we_o     = vld_p1;
  assign reg_waddr_o  = waddr_p1;
  assign reg_wdata_o  = wdata_p1;
  assign pipe_stall_o = (state_q == STALL);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LIM = 8;

  logic          clk;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          div_valid;
  logic [AW-1:0] div_waddr;
  logic [DW-1:0] div_wdata;
  logic          div_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_ready;
  logic          pipe_stall;
  logic          reg_we;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we_i    (pipe_we),
    .pipe_waddr_i (pipe_waddr),
    .pipe_wdata_i (pipe_wdata),
    .div_valid_i  (div_valid),
    .div_waddr_i  (div_waddr),
    .div_wdata_i  (div_wdata),
    .div_ready_o  (div_ready),
    .lsu_valid_i  (lsu_valid),
    .lsu_waddr_i  (lsu_waddr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_ready_o  (lsu_ready),
    .pipe_stall_o (pipe_stall),
    .reg_we_o     (reg_we),
    .reg_waddr_o  (reg_waddr),
    .reg_wdata_o  (reg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    div_valid = dv; div_waddr = da; div_wdata = dd;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit after a rising edge with rst released: cycle 0.
  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(1, 5'd3, 32'h0000_00AA, 0, 0, 0, 0, 0, 0);
    step();
    // Outputs now carry the write; assert reset mid-cycle with valids high.
    set_in(0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (reg_we !== 1'b0 || reg_waddr !== '0 || reg_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%0b waddr=%0d wdata=%h, want 0/0/0", reg_we, reg_waddr, reg_wdata);
    end
    checks++;
    if (div_ready !== 1'b0 || lsu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_readys: got div_ready=%0b lsu_ready=%0b stall=%0b, want 0/0/0", div_ready, lsu_ready, pipe_stall);
    end
    step();
    step();
    checks++;
    if (div_ready !== 1'b0 || lsu_ready !== 1'b0 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got div_ready=%0b lsu_ready=%0b we=%0b, want 0/0/0", div_ready, lsu_ready, reg_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (div_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_grant: got div_ready=%0b lsu_ready=%0b, want 1/0", div_ready, lsu_ready);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd4 || reg_wdata !== 32'h44) begin
      errors++;
      $display("FAIL reset_release_write: got we=%0b waddr=%0d wdata=%h, want 1/4/44", reg_we, reg_waddr, reg_wdata);
    end
  endtask

  task automatic test_pipe_priority();
    do_reset();
    set_in(1, 5'd3, 32'hDEAD_BEEF, 1, 5'd7, 32'h0000_0777, 0, 0, 0);
    #1;
    checks++;
    if (div_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got div_ready=%0b lsu_ready=%0b, want 0/0", div_ready, lsu_ready);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd3 || reg_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL prio_write: got we=%0b waddr=%0d wdata=%h, want 1/3/deadbeef", reg_we, reg_waddr, reg_wdata);
    end
    pipe_we = 1'b0;
    #1;
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_free_slot: got div_ready=%0b, want 1", div_ready);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd7 || reg_wdata !== 32'h0000_0777) begin
      errors++;
      $display("FAIL prio_div_write: got we=%0b waddr=%0d wdata=%h, want 1/7/777", reg_we, reg_waddr, reg_wdata);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    logic exp_div;
    do_reset();
    set_in(0, 0, 0, 1, 5'd5, 32'h0000_0055, 1, 5'd9, 32'h0000_0099);
    for (int i = 0; i < 4; i++) begin
      exp_div = ((i % 2) == 0);
      #1;
      checks++;
      if (div_ready !== exp_div || lsu_ready !== !exp_div) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got div_ready=%0b lsu_ready=%0b, want %0b/%0b", i, div_ready, lsu_ready, exp_div, !exp_div);
      end
      step();
      checks++;
      if (reg_we !== 1'b1 || reg_waddr !== (exp_div ? 5'd5 : 5'd9) || reg_wdata !== (exp_div ? 32'h55 : 32'h99)) begin
        errors++;
        $display("FAIL rr_write[%0d]: got we=%0b waddr=%0d wdata=%h, want 1/%0d/%h", i, reg_we, reg_waddr, reg_wdata,
                 exp_div ? 5 : 9, exp_div ? 32'h55 : 32'h99);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_starvation();
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      set_in(1, 5'd1, DW'(c), 0, 0, 0, (c <= 9), 5'd12, 32'h00C0_FFEE);
      #1;
      checks++;
      if (pipe_stall !== (c == 9) || lsu_ready !== (c == 9)) begin
        errors++;
        $display("FAIL starve_cycle[%0d]: got stall=%0b lsu_ready=%0b, want %0b/%0b", c, pipe_stall, lsu_ready, c == 9, c == 9);
      end
      if (c >= 1) begin
        exp_a = (c == 10) ? 5'd12 : 5'd1;
        exp_d = (c == 10) ? 32'h00C0_FFEE : DW'(c - 1);
        checks++;
        if (reg_we !== 1'b1 || reg_waddr !== exp_a || reg_wdata !== exp_d) begin
          errors++;
          $display("FAIL starve_write[%0d]: got we=%0b waddr=%0d wdata=%h, want 1/%0d/%h", c, reg_we, reg_waddr, reg_wdata, exp_a, exp_d);
        end
      end
      if (c == 10) begin
        checks++;
        if (dut.starve_cnt_q !== 8'd0) begin
          errors++;
          $display("FAIL starve_cnt_clear: got %0d, want 0", dut.starve_cnt_q);
        end
      end else begin
        step();
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_x0_write();
    do_reset();
    set_in(0, 0, 0, 1, 5'd0, 32'h0000_1234, 0, 0, 0);
    #1;
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got div_ready=%0b, want 1", div_ready);
    end
    step();
    checks++;
    if (reg_we !== 1'b0) begin
      errors++;
      $display("FAIL x0_we: got we=%0b, want 0", reg_we);
    end
    checks++;
    if (dut.rr_q !== 1'b1) begin
      errors++;
      $display("FAIL x0_rr: got rr=%0b, want 1", dut.rr_q);
    end
    // With rr now pointing at the LSU, it wins a contested slot.
    set_in(0, 0, 0, 1, 5'd2, 32'h22, 1, 5'd8, 32'h88);
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || div_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_rr_follow: got div_ready=%0b lsu_ready=%0b, want 0/1", div_ready, lsu_ready);
    end
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      set_in(1, 5'd1, 32'h1, 1, 5'd10, 32'h0000_0AAA, 0, 0, 0);
      step();
    end
    // Cycle 9: the stall is active.
    #1;
    checks++;
    if (pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL areset_stall_entry: got stall=%0b, want 1", pipe_stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pipe_stall !== 1'b0 || div_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_stall_drop: got stall=%0b div_ready=%0b, want 0/0", pipe_stall, div_ready);
    end
    step();
    rst = 1'b0;
    pipe_we = 1'b0;
    #1;
    checks++;
    if (pipe_stall !== 1'b0 || dut.starve_cnt_q !== 8'd0 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL areset_state: got stall=%0b cnt=%0d we=%0b, want 0/0/0", pipe_stall, dut.starve_cnt_q, reg_we);
    end
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_regrant: got div_ready=%0b, want 1", div_ready);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd10 || reg_wdata !== 32'h0000_0AAA) begin
      errors++;
      $display("FAIL areset_write: got we=%0b waddr=%0d wdata=%h, want 1/10/aaa", reg_we, reg_waddr, reg_wdata);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_pipe_priority();
    test_round_robin();
    test_starvation();
    test_x0_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
